lc3_operand_fetch: RTL and testbench
====================================

# lc3_operand_fetch

Operand-fetch stage for the LC-3 core. Accepts decoded instructions over a valid/ready handshake and drives the two read ports of the register file. It tracks pending register writebacks in an 8-entry scoreboard to stall RAW/WAW hazards, and forwards same-cycle writeback data. Operands go to the execute stage over a second valid/ready handshake.

## Interface
Parameters:
- none (width fixed: 8 regs × 16 bits).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- dec_valid  in  1  decoded instruction present.
- dec_ready  out  1  stage accepts instruction this cycle.
- dec_sr1, dec_sr2  in  3 each  source register addresses.
- dec_use_sr1, dec_use_sr2  in  1 each  source is read; unused source yields operand 0.
- dec_dr  in  3  destination register.
- dec_wr_dr  in  1  instruction will write dec_dr.
- dec_ctrl  in  16  opaque payload (imm/PC/opcode), passed through.
- rf_ren0, rf_ren1  out  1 each  register-file read enables.
- rf_raddr0, rf_raddr1  out  3 each  register-file read addresses.
- rf_rdata0, rf_rdata1  in  16 each  register-file read data, registered, 1-cycle latency.
- wb_valid  in  1  writeback to register file this cycle.
- wb_addr  in  3  writeback address.
- wb_data  in  16  writeback data.
- out_valid  out  1  operands valid to execute.
- out_ready  in  1  execute accepts.
- out_op1, out_op2  out  16 each  operand values.
- out_dr, out_wr_dr, out_ctrl  out  3/1/16  pass-through fields.
- sb_busy  out  8  scoreboard, bit n = reg n has pending write.

## Operation
- FSM states: IDLE, READ, VALID.
- Hazard, per used source s: sb_busy[s] && !(wb_valid && wb_addr==s). WAW hazard: dec_wr_dr && sb_busy[dec_dr] && !(wb_valid && wb_addr==dec_dr).
- dec_ready = (state==IDLE) && no hazard. It is combinational on the dec_* and wb_* inputs.
- IDLE:
  - On accept (dec_valid && dec_ready): rf_ren0/1 = dec_use_sr1/2 and rf_raddr0/1 = dec_sr1/2, both combinational in the accept cycle; all other times rf_ren = 0.
  - Capture dr, wr_dr, ctrl, and the use flags.
  - Per source, if wb_valid && wb_addr==src, capture wb_data into a bypass register and set its bypass flag.
  - Move to READ.
- READ: out_opN = use ? (bypass ? bypass_reg : rf_rdataN) : 16'h0000, latched at end of cycle. Move to VALID.
- VALID: out_valid=1 and outputs hold stable. On out_ready, move to IDLE. Throughput is at most one instruction per 3 cycles.
- Scoreboard:
  - On accept with dec_wr_dr, set sb_busy[dec_dr].
  - On wb_valid, clear sb_busy[wb_addr].
  - Set and clear of the same bit in the same cycle: set wins.
- A wb_valid to an address with no busy bit clears nothing harmful and is legal.
- R0–R7 have no special cases.

## Timing
- Reset values: state=IDLE, sb_busy=8'h00, out_valid=0, out_op1/op2=0, out_dr=0, out_wr_dr=0, out_ctrl=0, bypass flags=0.
- rf_ren0/1=0 and dec_ready=1 while reset is deasserted and the stage is idle.
- Latency: accept at edge E0, regfile data at E1, out_valid high after E2. 2 cycles from accept to out_valid.
- Reset mid-operation: an in-flight instruction is dropped and all busy bits are cleared.
- out_valid never drops without out_ready.

## Configuration
- LC3_OPFETCH_BYPASS_EN defined: same-cycle writeback forwarding as described above.
- Not defined:
  - A source or dest whose busy bit is set stalls even if wb_valid targets it this cycle.
  - The bypass registers and flags do not exist.
  - Operand always = rf_rdata (or 0 if unused).
  - The stall resolves one cycle later.

## Test plan
- After reset, accept sr1=R2, sr2=R3 with regfile R2=16'h1234, R3=16'hABCD → out_op1=16'h1234 and out_op2=16'hABCD, with out_valid 2 cycles after accept and sb_busy=0.
- Issue write-to-R1 (wr_dr=1, dr=1), then a reader of R1 → second instruction stalls (dec_ready=0) until wb_valid with addr=1 and data=16'h00FF. With the macro, it is accepted in that same cycle and out_op1=16'h00FF; without the macro, it is accepted one cycle later, with the same value.
- WAW: two writers to R4 back to back → second stalls until R4 writeback; sb_busy[4] stays 1 across the clear/set cycle.
- Hold out_ready=0 for 5 cycles in VALID → out_valid and all out_* stay stable; dec_ready=0 throughout.
- use_sr2=0 with sr2=R7 holding 16'hFFFF → out_op2=0 and rf_ren1=0.
- Assert rst_n low during READ with sb_busy=8'h10 → out_valid=0, sb_busy=0, and state returns to IDLE immediately (asynchronous).

Source files
------------

// File: rtl/lc3_operand_fetch_if.sv
// Signal bundle of the LC-3 operand-fetch stage: decode input, register-file read ports,
// writeback snoop, execute output and scoreboard view. The stage uses the slave modport.
interface lc3_operand_fetch_if;
  logic        dec_valid;
  logic        dec_ready;
  logic [2:0]  dec_sr1;
  logic [2:0]  dec_sr2;
  logic        dec_use_sr1;
  logic        dec_use_sr2;
  logic [2:0]  dec_dr;
  logic        dec_wr_dr;
  logic [15:0] dec_ctrl;

  logic        rf_ren0;
  logic        rf_ren1;
  logic [2:0]  rf_raddr0;
  logic [2:0]  rf_raddr1;
  logic [15:0] rf_rdata0;
  logic [15:0] rf_rdata1;

  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_op1;
  logic [15:0] out_op2;
  logic [2:0]  out_dr;
  logic        out_wr_dr;
  logic [15:0] out_ctrl;

  logic [7:0]  sb_busy;

  modport slave (
    input  dec_valid, dec_sr1, dec_sr2, dec_use_sr1, dec_use_sr2, dec_dr, dec_wr_dr, dec_ctrl,
    input  rf_rdata0, rf_rdata1, wb_valid, wb_addr, wb_data, out_ready,
    output dec_ready, rf_ren0, rf_ren1, rf_raddr0, rf_raddr1,
    output out_valid, out_op1, out_op2, out_dr, out_wr_dr, out_ctrl, sb_busy
  );

  modport master (
    output dec_valid, dec_sr1, dec_sr2, dec_use_sr1, dec_use_sr2, dec_dr, dec_wr_dr, dec_ctrl,
    output rf_rdata0, rf_rdata1, wb_valid, wb_addr, wb_data, out_ready,
    input  dec_ready, rf_ren0, rf_ren1, rf_raddr0, rf_raddr1,
    input  out_valid, out_op1, out_op2, out_dr, out_wr_dr, out_ctrl, sb_busy
  );
endinterface

// File: rtl/lc3_operand_fetch.sv
// LC-3 operand-fetch stage: scoreboarded RAW/WAW stall, regfile read, operand hand-off.
// Define LC3_OPFETCH_BYPASS_EN to forward same-cycle writeback data instead of stalling a cycle.
module lc3_operand_fetch (
  input logic                clk,
  input logic                rst_n,
  lc3_operand_fetch_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StRead, StValid} state_e;

  state_e      state_q, state_d;
  logic [7:0]  sb_q, sb_d;
  logic [15:0] op1_q, op1_d, op2_q, op2_d, ctrl_q, ctrl_d;
  logic [2:0]  dr_q, dr_d;
  logic        wr_dr_q, wr_dr_d, use1_q, use1_d, use2_q, use2_d;
  logic        wb_hit1, wb_hit2, wb_hitd;
  logic        hazard, ready, accept;
  logic [15:0] src1, src2;

`ifdef LC3_OPFETCH_BYPASS_EN
  logic [15:0] byp1_q, byp1_d, byp2_q, byp2_d;
  logic        bypf1_q, bypf1_d, bypf2_q, bypf2_d;

  assign wb_hit1 = bus.wb_valid && (bus.wb_addr == bus.dec_sr1);
  assign wb_hit2 = bus.wb_valid && (bus.wb_addr == bus.dec_sr2);
  assign wb_hitd = bus.wb_valid && (bus.wb_addr == bus.dec_dr);
  // The regfile returns pre-write data for a same-cycle writeback, so the bypass copy wins.
  assign src1    = bypf1_q ? byp1_q : bus.rf_rdata0;
  assign src2    = bypf2_q ? byp2_q : bus.rf_rdata1;

  always_comb begin
    bypf1_d = bypf1_q;
    bypf2_d = bypf2_q;
    byp1_d  = byp1_q;
    byp2_d  = byp2_q;
    if (accept) begin
      bypf1_d = wb_hit1;
      bypf2_d = wb_hit2;
      byp1_d  = bus.wb_data;
      byp2_d  = bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bypf1_q <= 1'b0;
      bypf2_q <= 1'b0;
      byp1_q  <= 16'h0000;
      byp2_q  <= 16'h0000;
    end else begin
      bypf1_q <= bypf1_d;
      bypf2_q <= bypf2_d;
      byp1_q  <= byp1_d;
      byp2_q  <= byp2_d;
    end
  end
`else
  assign wb_hit1 = 1'b0;
  assign wb_hit2 = 1'b0;
  assign wb_hitd = 1'b0;
  assign src1    = bus.rf_rdata0;
  assign src2    = bus.rf_rdata1;
`endif

  always_comb begin
    hazard = (bus.dec_use_sr1 && sb_q[bus.dec_sr1] && !wb_hit1) ||
             (bus.dec_use_sr2 && sb_q[bus.dec_sr2] && !wb_hit2) ||
             (bus.dec_wr_dr   && sb_q[bus.dec_dr]  && !wb_hitd);
    ready  = (state_q == StIdle) && !hazard;
    accept = bus.dec_valid && ready;
  end

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    ctrl_d  = ctrl_q;
    dr_d    = dr_q;
    wr_dr_d = wr_dr_q;
    use1_d  = use1_q;
    use2_d  = use2_q;
    sb_d    = sb_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          dr_d    = bus.dec_dr;
          wr_dr_d = bus.dec_wr_dr;
          ctrl_d  = bus.dec_ctrl;
          use1_d  = bus.dec_use_sr1;
          use2_d  = bus.dec_use_sr2;
          state_d = StRead;
        end
      end
      StRead: begin
        op1_d   = use1_q ? src1 : 16'h0000;
        op2_d   = use2_q ? src2 : 16'h0000;
        state_d = StValid;
      end
      StValid: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Set after clear so a same-cycle retire and reissue of a register keeps it busy.
    if (bus.wb_valid) sb_d[bus.wb_addr] = 1'b0;
    if (accept && bus.dec_wr_dr) sb_d[bus.dec_dr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sb_q    <= 8'h00;
      op1_q   <= 16'h0000;
      op2_q   <= 16'h0000;
      ctrl_q  <= 16'h0000;
      dr_q    <= 3'd0;
      wr_dr_q <= 1'b0;
      use1_q  <= 1'b0;
      use2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sb_q    <= sb_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      ctrl_q  <= ctrl_d;
      dr_q    <= dr_d;
      wr_dr_q <= wr_dr_d;
      use1_q  <= use1_d;
      use2_q  <= use2_d;
    end
  end

  always_comb begin
    bus.dec_ready = ready;
    bus.rf_ren0   = accept && bus.dec_use_sr1;
    bus.rf_ren1   = accept && bus.dec_use_sr2;
    bus.rf_raddr0 = bus.dec_sr1;
    bus.rf_raddr1 = bus.dec_sr2;
    bus.out_valid = (state_q == StValid);
    bus.out_op1   = op1_q;
    bus.out_op2   = op2_q;
    bus.out_dr    = dr_q;
    bus.out_wr_dr = wr_dr_q;
    bus.out_ctrl  = ctrl_q;
    bus.sb_busy   = sb_q;
  end
endmodule

// File: tb/tb_lc3_operand_fetch.sv
// Self-checking bench for lc3_operand_fetch: directed scenarios plus random traffic scored
// against a transaction-level model (pending-write set, register values, 2-cycle latency).
module tb_lc3_operand_fetch;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lc3_operand_fetch_if bus ();
  lc3_operand_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Environment register file: registered read, write on writeback.
  logic [15:0] mem [8];
  always @(posedge clk) begin
    if (bus.rf_ren0) bus.rf_rdata0 <= mem[bus.rf_raddr0];
    if (bus.rf_ren1) bus.rf_rdata1 <= mem[bus.rf_raddr1];
    if (bus.wb_valid) mem[bus.wb_addr] <= bus.wb_data;
  end

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state.
  bit          m_pend [8];
  bit          m_busy;
  int          m_age;
  logic [15:0] e_op1, e_op2, e_ctrl;
  logic [2:0]  e_dr;
  logic        e_wr;

  function automatic bit src_blocked(logic [2:0] r);
`ifdef LC3_OPFETCH_BYPASS_EN
    return m_pend[r] && !(bus.wb_valid && bus.wb_addr == r);
`else
    return m_pend[r];
`endif
  endfunction

  function automatic bit model_ready();
    if (m_busy) return 1'b0;
    if (bus.dec_use_sr1 && src_blocked(bus.dec_sr1)) return 1'b0;
    if (bus.dec_use_sr2 && src_blocked(bus.dec_sr2)) return 1'b0;
    if (bus.dec_wr_dr && src_blocked(bus.dec_dr)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] reg_value(logic [2:0] r);
    if (bus.wb_valid && bus.wb_addr == r) return bus.wb_data;
    return mem[r];
  endfunction

  function automatic logic [7:0] pend_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
    m_busy = 1'b0;
    m_age  = 0;
  endtask

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic cycle();
    bit acc;
    acc = bus.dec_valid && model_ready();
    if (acc) begin
      e_op1  = bus.dec_use_sr1 ? reg_value(bus.dec_sr1) : 16'h0000;
      e_op2  = bus.dec_use_sr2 ? reg_value(bus.dec_sr2) : 16'h0000;
      e_ctrl = bus.dec_ctrl;
      e_dr   = bus.dec_dr;
      e_wr   = bus.dec_wr_dr;
    end
    @(posedge clk);
    if (m_busy) begin
      if (m_age >= 2 && bus.out_ready) m_busy = 1'b0;
      else m_age++;
    end
    if (bus.wb_valid) m_pend[bus.wb_addr] = 1'b0;
    if (acc) begin
      if (bus.dec_wr_dr) m_pend[bus.dec_dr] = 1'b1;
      m_busy = 1'b1;
      m_age  = 1;
    end
    #1;
  endtask

  task automatic drive_dec(logic [2:0] sr1, logic [2:0] sr2, logic u1, logic u2,
                           logic [2:0] dr, logic wr, logic [15:0] ctrl);
    bus.dec_valid   = 1'b1;
    bus.dec_sr1     = sr1;
    bus.dec_sr2     = sr2;
    bus.dec_use_sr1 = u1;
    bus.dec_use_sr2 = u2;
    bus.dec_dr      = dr;
    bus.dec_wr_dr   = wr;
    bus.dec_ctrl    = ctrl;
  endtask

  task automatic write_reg(logic [2:0] r, logic [15:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = r;
    bus.wb_data  = d;
    cycle();
    bus.wb_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
  endtask

  task automatic drive_wb_random(bit force_wb);
    logic [2:0] cand [$];
    for (int i = 0; i < 8; i++) if (m_pend[i]) cand.push_back(3'(i));
    bus.wb_valid = 1'b0;
    if (cand.size() != 0 && (force_wb || $urandom_range(0, 2) == 0)) begin
      bus.wb_valid = 1'b1;
      bus.wb_addr  = cand[$urandom_range(0, cand.size() - 1)];
      bus.wb_data  = 16'($urandom);
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.sb_busy !== 8'h00) begin n_err++; $display("FAIL rst_sb_busy: got %h want 00", bus.sb_busy); end
    n_checks++; if ({bus.out_op1, bus.out_op2, bus.out_ctrl} !== 48'h0) begin n_err++; $display("FAIL rst_out_data: got %h %h %h want 0", bus.out_op1, bus.out_op2, bus.out_ctrl); end
    n_checks++; if ({bus.out_dr, bus.out_wr_dr} !== 4'h0) begin n_err++; $display("FAIL rst_out_dr: got %h %b want 0", bus.out_dr, bus.out_wr_dr); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.dec_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready: got %b want 1", bus.dec_ready); end
    n_checks++; if ({bus.rf_ren0, bus.rf_ren1} !== 2'b00) begin n_err++; $display("FAIL idle_ren: got %b want 00", {bus.rf_ren0, bus.rf_ren1}); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    drive_dec(3'd2, 3'd3, 1'b1, 1'b1, 3'd5, 1'b0, 16'hC0DE);
    #1;
    n_checks++; if (bus.dec_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", bus.dec_ready); end
    n_checks++; if ({bus.rf_ren0, bus.rf_ren1} !== 2'b11) begin n_err++; $display("FAIL basic_ren: got %b want 11", {bus.rf_ren0, bus.rf_ren1}); end
    n_checks++; if ({bus.rf_raddr0, bus.rf_raddr1} !== {3'd2, 3'd3}) begin n_err++; $display("FAIL basic_raddr: got %0d %0d want 2 3", bus.rf_raddr0, bus.rf_raddr1); end
    cycle();
    bus.dec_valid = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", bus.out_valid); end
    cycle();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", bus.out_valid); end
    n_checks++; if ({bus.out_op1, bus.out_op2} !== {16'h1234, 16'hABCD}) begin n_err++; $display("FAIL basic_ops: got %h %h want 1234 abcd", bus.out_op1, bus.out_op2); end
    n_checks++; if ({bus.out_ctrl, bus.out_dr, bus.out_wr_dr} !== {16'hC0DE, 3'd5, 1'b0}) begin n_err++; $display("FAIL basic_pass: got %h %0d %b want c0de 5 0", bus.out_ctrl, bus.out_dr, bus.out_wr_dr); end
    n_checks++; if (bus.sb_busy !== 8'h00) begin n_err++; $display("FAIL basic_sb: got %h want 00", bus.sb_busy); end
    drain();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drop: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_unused_src();
    drive_dec(3'd2, 3'd7, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0042);
    #1;
    n_checks++; if ({bus.rf_ren0, bus.rf_ren1} !== 2'b10) begin n_err++; $display("FAIL unused_ren: got %b want 10", {bus.rf_ren0, bus.rf_ren1}); end
    cycle();
    bus.dec_valid = 1'b0;
    cycle();
    n_checks++; if ({bus.out_op1, bus.out_op2} !== {16'h1234, 16'h0000}) begin n_err++; $display("FAIL unused_ops: got %h %h want 1234 0000", bus.out_op1, bus.out_op2); end
    drain();
  endtask

  task automatic test_hold();
    drive_dec(3'd7, 3'd2, 1'b1, 1'b1, 3'd6, 1'b0, 16'h5A5A);
    cycle();
    bus.dec_valid = 1'b0;
    cycle();
    drive_dec(3'd1, 3'd1, 1'b1, 1'b1, 3'd0, 1'b0, 16'h0000);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_op1 !== 16'hFFFF || bus.out_op2 !== 16'h1234 || bus.out_ctrl !== 16'h5A5A || bus.out_dr !== 3'd6) begin
        n_err++; $display("FAIL hold_out[%0d]: got v=%b %h %h %h %0d want 1 ffff 1234 5a5a 6", c, bus.out_valid, bus.out_op1, bus.out_op2, bus.out_ctrl, bus.out_dr);
      end
      n_checks++; if (bus.dec_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d]: got %b want 0", c, bus.dec_ready); end
      cycle();
    end
    bus.dec_valid = 1'b0;
    drain();
  endtask

  task automatic test_raw();
    drive_dec(3'd0, 3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 16'h1111);
    cycle();
    bus.dec_valid = 1'b0;
    cycle();
    drain();
    n_checks++; if (bus.sb_busy !== 8'h02) begin n_err++; $display("FAIL raw_sb: got %h want 02", bus.sb_busy); end
    drive_dec(3'd1, 3'd0, 1'b1, 1'b0, 3'd2, 1'b0, 16'h2222);
    #1;
    n_checks++; if (bus.dec_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall: got %b want 0", bus.dec_ready); end
    cycle();
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 3'd1;
    bus.wb_data  = 16'h00FF;
    #1;
`ifdef LC3_OPFETCH_BYPASS_EN
    n_checks++; if (bus.dec_ready !== 1'b1) begin n_err++; $display("FAIL raw_wb_ready: got %b want 1", bus.dec_ready); end
    cycle();
    bus.wb_valid = 1'b0;
`else
    n_checks++; if (bus.dec_ready !== 1'b0) begin n_err++; $display("FAIL raw_wb_ready: got %b want 0", bus.dec_ready); end
    cycle();
    bus.wb_valid = 1'b0;
    #1;
    n_checks++; if (bus.dec_ready !== 1'b1) begin n_err++; $display("FAIL raw_late_ready: got %b want 1", bus.dec_ready); end
    cycle();
`endif
    bus.dec_valid = 1'b0;
    cycle();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_op1 !== 16'h00FF || bus.out_op2 !== 16'h0000) begin
      n_err++; $display("FAIL raw_ops: got v=%b %h %h want 1 00ff 0000", bus.out_valid, bus.out_op1, bus.out_op2);
    end
    drain();
  endtask

  task automatic test_waw();
    drive_dec(3'd0, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1, 16'h4444);
    cycle();
    drive_dec(3'd0, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1, 16'h4445);
    cycle();
    cycle();
    drain();
    #1;
    n_checks++; if (bus.dec_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall: got %b want 0", bus.dec_ready); end
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 3'd4;
    bus.wb_data  = 16'h0BAD;
    #1;
`ifdef LC3_OPFETCH_BYPASS_EN
    n_checks++; if (bus.dec_ready !== 1'b1) begin n_err++; $display("FAIL waw_wb_ready: got %b want 1", bus.dec_ready); end
    cycle();
    bus.wb_valid = 1'b0;
`else
    n_checks++; if (bus.dec_ready !== 1'b0) begin n_err++; $display("FAIL waw_wb_ready: got %b want 0", bus.dec_ready); end
    cycle();
    bus.wb_valid = 1'b0;
    #1;
    n_checks++; if (bus.sb_busy[4] !== 1'b0) begin n_err++; $display("FAIL waw_cleared: got %b want 0", bus.sb_busy[4]); end
    cycle();
`endif
    bus.dec_valid = 1'b0;
    n_checks++; if (bus.sb_busy[4] !== 1'b1) begin n_err++; $display("FAIL waw_busy: got %b want 1", bus.sb_busy[4]); end
    cycle();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== 16'h4445) begin n_err++; $display("FAIL waw_out: got v=%b %h want 1 4445", bus.out_valid, bus.out_ctrl); end
    drain();
    write_reg(3'd4, 16'h0444);
    n_checks++; if (bus.sb_busy !== 8'h00) begin n_err++; $display("FAIL waw_final_sb: got %h want 00", bus.sb_busy); end
  endtask

  task automatic test_reset_mid();
    drive_dec(3'd0, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1, 16'h7777);
    cycle();
    bus.dec_valid = 1'b0;
    n_checks++; if (bus.sb_busy !== 8'h10) begin n_err++; $display("FAIL mid_sb_pre: got %h want 10", bus.sb_busy); end
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.sb_busy !== 8'h00) begin n_err++; $display("FAIL mid_sb: got %h want 00", bus.sb_busy); end
    n_checks++; if (bus.dec_ready !== 1'b1) begin n_err++; $display("FAIL mid_idle: got %b want 1", bus.dec_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_dec(3'd2, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0001);
    cycle();
    bus.dec_valid = 1'b0;
    cycle();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_op1 !== 16'h1234) begin n_err++; $display("FAIL mid_resume: got v=%b %h want 1 1234", bus.out_valid, bus.out_op1); end
    drain();
  endtask

  task automatic test_random();
    bit done;
    int hold;
    for (int n = 0; n < 60; n++) begin
      drive_dec(3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                1'($urandom), 16'($urandom));
      done = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
        drive_wb_random(c > 3);
        #1;
        n_checks++; if (bus.dec_ready !== model_ready()) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, bus.dec_ready, model_ready()); end
        n_checks++; if (bus.sb_busy !== pend_vec()) begin n_err++; $display("FAIL rnd_sb[%0d]: got %h want %h", n, bus.sb_busy, pend_vec()); end
        if (model_ready()) begin
          n_checks++; if ({bus.rf_ren0, bus.rf_ren1} !== {bus.dec_use_sr1, bus.dec_use_sr2} || bus.rf_raddr0 !== bus.dec_sr1 || bus.rf_raddr1 !== bus.dec_sr2) begin
            n_err++; $display("FAIL rnd_rf[%0d]: got %b %0d %0d want %b %0d %0d", n, {bus.rf_ren0, bus.rf_ren1}, bus.rf_raddr0, bus.rf_raddr1, {bus.dec_use_sr1, bus.dec_use_sr2}, bus.dec_sr1, bus.dec_sr2);
          end
          done = 1'b1;
        end
        cycle();
      end
      bus.dec_valid = 1'b0;
      if (!done) begin
        n_checks++; n_err++; $display("FAIL rnd_accept_timeout[%0d]: got no accept want accept", n);
        break;
      end
      drive_wb_random(1'b0);
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rnd_early_valid[%0d]: got %b want 0", n, bus.out_valid); end
      cycle();
      hold = $urandom_range(0, 2);
      for (int c = 0; c <= hold; c++) begin
        drive_wb_random(1'b0);
        bus.out_ready = (c == hold);
        #1;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_op1 !== e_op1 || bus.out_op2 !== e_op2 || bus.out_ctrl !== e_ctrl || bus.out_dr !== e_dr || bus.out_wr_dr !== e_wr) begin
          n_err++; $display("FAIL rnd_out[%0d]: got v=%b %h %h %h %0d %b want 1 %h %h %h %0d %b", n, bus.out_valid, bus.out_op1, bus.out_op2, bus.out_ctrl, bus.out_dr, bus.out_wr_dr, e_op1, e_op2, e_ctrl, e_dr, e_wr);
        end
        cycle();
      end
      bus.out_ready = 1'b0;
      bus.wb_valid  = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.dec_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_addr   = 3'd0;
    bus.wb_data   = 16'h0000;
    drive_dec(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000);
    bus.dec_valid = 1'b0;
    model_reset();
    #12;
    test_reset();
    for (int i = 0; i < 8; i++) write_reg(3'(i), 16'($urandom));
    write_reg(3'd2, 16'h1234);
    write_reg(3'd3, 16'hABCD);
    write_reg(3'd7, 16'hFFFF);
    test_basic();
    test_unused_src();
    test_hold();
    test_raw();
    test_waw();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
